// File: rtl/demux4_stream_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the 1:4 stream demultiplexer.
//   NUM_PORTS  : number of output streams
//   FIFO_DEPTH : entries per output queue
//   port_idx_t : destination port index (2 bits)
//   occ_t      : queue occupancy (0..FIFO_DEPTH)
// ----------------------------------------------------------------------------
package demux_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int FIFO_DEPTH = 2;

   typedef logic [1:0] port_idx_t;
   typedef logic [1:0] occ_t;

endpackage : demux_pkg

// File: rtl/demux4_stream_if.sv
// ----------------------------------------------------------------------------
// demux4_stream_if
// Bundles the input stream, the four output streams and the busy flag.
//   in_data/in_sel/in_valid  : upstream payload, destination, valid
//   in_ready                 : block can accept the payload for in_sel
//   out0..out3               : head data of each port queue
//   out_valid/out_ready      : per-port handshake, bit k = port k
//   busy                     : any port queue non-empty
// Modports: master = stimulus/consumer side, slave = the demux itself.
// ----------------------------------------------------------------------------
interface demux4_stream_if #(
   parameter int N = 32
);
   import demux_pkg::*;

   logic [N-1:0]           in_data;
   port_idx_t              in_sel;
   logic                   in_valid;
   logic                   in_ready;
   logic [N-1:0]           out0;
   logic [N-1:0]           out1;
   logic [N-1:0]           out2;
   logic [N-1:0]           out3;
   logic [NUM_PORTS-1:0]   out_valid;
   logic [NUM_PORTS-1:0]   out_ready;
   logic                   busy;

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out0, out1, out2, out3, out_valid, busy
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out0, out1, out2, out3, out_valid, busy
   );

endinterface : demux4_stream_if

// File: rtl/demux4_stream_fifo2.sv
// ----------------------------------------------------------------------------
// stream_fifo2
// Two-entry N-bit FIFO with registered occupancy.
//   clk, rst  : clock, asynchronous active-low reset
//   i_push    : append i_data (ignored when full)
//   i_data    : payload to append
//   i_pop     : drop the head entry (ignored when empty)
//   o_full    : occupancy == FIFO_DEPTH
//   o_empty   : occupancy == 0
//   o_head    : oldest entry, meaningful only while !o_empty
// ----------------------------------------------------------------------------
module stream_fifo2
   import demux_pkg::*;
#(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [N-1:0]  i_data,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [N-1:0]  o_head
);

   logic [N-1:0] r_mem [FIFO_DEPTH];
   logic         r_wptr;
   logic         r_rptr;
   occ_t         r_count;

   logic         w_push;
   logic         w_pop;

   assign o_full  = (r_count == occ_t'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);

   // Guard against overflow/underflow so callers may drive push/pop freely.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         // Push+pop together leaves occupancy unchanged; with one entry the
         // read pointer moves onto the slot just written, so the new entry
         // becomes head on the next cycle.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; head is only looked at when valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_head = r_mem[r_rptr];

endmodule : stream_fifo2

// File: rtl/demux4_stream.sv
// ----------------------------------------------------------------------------
// demux4_stream
// Routes one valid/ready input stream to one of four output streams chosen
// by in_sel. Each port has its own 2-entry queue, so a stalled consumer only
// blocks traffic addressed to its own port.
//   clk  : system clock
//   rst  : asynchronous active-low reset (clears all queues)
//   bus  : demux4_stream_if slave view (input stream, 4 output streams, busy)
// ----------------------------------------------------------------------------
module demux4_stream
   import demux_pkg::*;
#(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   demux4_stream_if.slave    bus
);

   logic [NUM_PORTS-1:0] w_push;
   logic [NUM_PORTS-1:0] w_full;
   logic [NUM_PORTS-1:0] w_empty;
   logic [N-1:0]         w_head [NUM_PORTS];
   logic                 w_in_ready;

   // Readiness depends only on registered occupancy of the addressed port,
   // never on out_ready, which keeps the input and output handshakes apart.
   assign w_in_ready = ~w_full[bus.in_sel];

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign w_push[gi] = bus.in_valid & w_in_ready
                           & (bus.in_sel == port_idx_t'(gi));

         stream_fifo2 #(
            .N (N)
         ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[gi]),
            .i_data  (bus.in_data),
            .i_pop   (bus.out_ready[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_head  (w_head[gi])
         );
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = ~w_empty;
   assign bus.busy      = |(~w_empty);
   assign bus.out0      = w_head[0];
   assign bus.out1      = w_head[1];
   assign bus.out2      = w_head[2];
   assign bus.out3      = w_head[3];

endmodule : demux4_stream

// File: tb/tb_demux4_stream.sv
// ----------------------------------------------------------------------------
// tb_demux4_stream
// Self-checking bench for demux4_stream: a queue-per-port reference model,
// a per-cycle compare process, directed literal checks and a random run.
// ----------------------------------------------------------------------------
module tb_demux4_stream;
   import demux_pkg::*;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   bit   check_en;

   // Reference model: one plain queue per port, oldest entry at index 0.
   logic [31:0] mq [4][$];

   demux4_stream_if #(.N(32)) bus ();

   demux4_stream #(.N(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] head_of(input int k);
      case (k)
         0:       return bus.out0;
         1:       return bus.out1;
         2:       return bus.out2;
         default: return bus.out3;
      endcase
   endfunction

   // Model update: readiness is judged from occupancy before this edge's pops.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else begin
         int  s;
         bit  rdy;
         s   = int'(bus.in_sel);
         rdy = (mq[s].size() < 2);
         for (int k = 0; k < 4; k++)
            if (bus.out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
         if (bus.in_valid && rdy) mq[s].push_back(bus.in_data);
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         logic [3:0] ev;
         for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
         chk("cmp_out_valid", 32'(bus.out_valid), 32'(ev));
         chk("cmp_busy", 32'(bus.busy), 32'(|ev));
         chk("cmp_in_ready", 32'(bus.in_ready), 32'(mq[int'(bus.in_sel)].size() < 2));
         for (int k = 0; k < 4; k++)
            if (ev[k]) chk($sformatf("cmp_head%0d", k), head_of(k), mq[k][0]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int sel, input logic [31:0] d, input logic [3:0] rdy);
      bus.in_valid  = v;
      bus.in_sel    = port_idx_t'(sel);
      bus.in_data   = d;
      bus.out_ready = rdy;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      check_en = 1'b0;
      rst      = 1'b0;
      drive(0, 0, 32'h0, 4'b0000);

      // Reset and idle
      repeat (2) cyc();
      check_en = 1'b1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      rst = 1'b1;
      cyc();
      chk("idle_out_valid", 32'(bus.out_valid), 32'h0);

      // Single payload to port 2, one-cycle latency
      drive(1, 2, 32'hA5A5_A5A5, 4'b0000);
      chk("p2_in_ready", 32'(bus.in_ready), 32'h1);
      cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("p2_out2", bus.out2, 32'hA5A5_A5A5);
      chk("p2_out_valid", 32'(bus.out_valid), 32'h4);
      chk("p2_busy", 32'(bus.busy), 32'h1);
      drive(0, 0, 32'h0, 4'b0100);
      cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("p2_drained", 32'(bus.out_valid), 32'h0);

      // Fill port 1, stall the third payload, then drain in order
      drive(1, 1, 32'h11, 4'b0000); cyc();
      drive(1, 1, 32'h22, 4'b0000); cyc();
      drive(1, 1, 32'h33, 4'b0000);
      chk("p1_full_ready", 32'(bus.in_ready), 32'h0);
      cyc();
      chk("p1_stall_ready", 32'(bus.in_ready), 32'h0);
      chk("p1_head_11", bus.out1, 32'h11);
      chk("p1_out_valid", 32'(bus.out_valid), 32'h2);
      drive(1, 1, 32'h33, 4'b0010);
      chk("p1_ready_no_comb", 32'(bus.in_ready), 32'h0);
      cyc();
      chk("p1_head_22", bus.out1, 32'h22);
      chk("p1_ready_rise", 32'(bus.in_ready), 32'h1);
      cyc();
      chk("p1_head_33", bus.out1, 32'h33);
      drive(0, 0, 32'h0, 4'b0010);
      cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("p1_drained", 32'(bus.out_valid), 32'h0);

      // Push and pop together at occupancy 1
      drive(1, 0, 32'h5, 4'b0000); cyc();
      chk("p0_head_5", bus.out0, 32'h5);
      drive(1, 0, 32'h6, 4'b0001); cyc();
      chk("p0_head_6", bus.out0, 32'h6);
      chk("p0_occ1", 32'(bus.out_valid), 32'h1);
      drive(0, 0, 32'h0, 4'b0001); cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("p0_drained", 32'(bus.out_valid), 32'h0);

      // Ports 0 and 3 full, simultaneous pops
      drive(1, 0, 32'h1, 4'b0000); cyc();
      drive(1, 0, 32'h2, 4'b0000); cyc();
      drive(1, 3, 32'h3, 4'b0000); cyc();
      drive(1, 3, 32'h4, 4'b0000); cyc();
      drive(0, 0, 32'h0, 4'b1001); cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("dual_out0", bus.out0, 32'h2);
      chk("dual_out3", bus.out3, 32'h4);
      chk("dual_valid", 32'(bus.out_valid), 32'h9);
      chk("dual_busy", 32'(bus.busy), 32'h1);
      drive(0, 0, 32'h0, 4'b1001); cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("dual_empty", 32'(bus.out_valid), 32'h0);
      chk("dual_busy_low", 32'(bus.busy), 32'h0);

      // Reset mid-stream discards queued payloads
      drive(1, 1, 32'hDEAD_0001, 4'b0000); cyc();
      drive(1, 2, 32'hDEAD_0002, 4'b0000); cyc();
      drive(1, 2, 32'hDEAD_0003, 4'b0000);
      rst = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
      drive(0, 0, 32'h0, 4'b0000);
      cyc();
      rst = 1'b1;
      cyc();
      chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("post_rst_busy", 32'(bus.busy), 32'h0);

      // Randomised traffic against the queue model
      for (int i = 0; i < 10000; i++) begin
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
               4'($urandom_range(0, 15)));
         cyc();
      end
      drive(0, 0, 32'h0, 4'b1111);
      repeat (4) cyc();
      drive(0, 0, 32'h0, 4'b0000);
      chk("final_empty", 32'(bus.out_valid), 32'h0);
      chk("final_busy", 32'(bus.busy), 32'h0);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_demux4_stream
